// File: rtl/rob_tag_alloc.sv
// ROB tag allocator: hands out non-zero rename tags from a circular pool,
// drives the register file dependency write on each grant, reclaims tags
// in order on ROB commit and resets the pool on a pipeline clear.
module rob_tag_alloc #(
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 iu_req,
    input  logic [4:0]           iu_rd_id,
    output logic                 iu_grant,
    output logic [ROB_WIDTH-1:0] iu_tag,
    output logic                 rf_issue_ready,
    output logic [4:0]           rf_issue_rd_id,
    output logic [ROB_WIDTH-1:0] rf_issue_rob_idx,
    input  logic                 rob_commit,
    input  logic [ROB_WIDTH-1:0] rob_commit_idx,
    output logic [ROB_WIDTH-1:0] head_tag,
    output logic [ROB_WIDTH-1:0] free_cnt,
    output logic                 full,
    output logic                 empty,
    output logic                 err
);

    // Pool size; tag 0 is reserved as the "no dependency" value.
    localparam logic [ROB_WIDTH-1:0] PoolSize = {ROB_WIDTH{1'b1}};
    localparam logic [ROB_WIDTH-1:0] FirstTag = ROB_WIDTH'(1);

    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic active;
    logic grant;
    logic commit_ok;
    logic commit_bad;

    // Circular advance that skips tag 0.
    function automatic logic [ROB_WIDTH-1:0] next_ptr(input logic [ROB_WIDTH-1:0] p);
        return (p == PoolSize) ? FirstTag : p + FirstTag;
    endfunction

    // Grant/commit qualification from registered state and current inputs.
    always_comb begin
        active     = rdy_in & ~clr_in;
        grant      = iu_req & active & (cnt_q != PoolSize);
        commit_ok  = rob_commit & active & (cnt_q != '0) & (rob_commit_idx == head_q);
        commit_bad = rob_commit & active & ~commit_ok;
    end

    // Next-state: clear wins, otherwise pointers and count follow grant/commit.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        err_d  = err_q | commit_bad;
        if (rdy_in && clr_in) begin
            head_d = FirstTag;
            tail_d = FirstTag;
            cnt_d  = '0;
        end else begin
            if (grant) begin
                tail_d = next_ptr(tail_q);
            end
            if (commit_ok) begin
                head_d = next_ptr(head_q);
            end
            // Simultaneous grant and commit leave the count unchanged.
            if (grant && !commit_ok) begin
                cnt_d = cnt_q + FirstTag;
            end else if (!grant && commit_ok) begin
                cnt_d = cnt_q - FirstTag;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q <= FirstTag;
            tail_q <= FirstTag;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Issue and status outputs.
    always_comb begin
        iu_grant         = grant;
        iu_tag           = tail_q;
        rf_issue_ready   = grant;
        rf_issue_rd_id   = iu_rd_id;
        rf_issue_rob_idx = tail_q;
        head_tag         = head_q;
        free_cnt         = PoolSize - cnt_q;
        full             = (cnt_q == PoolSize);
        empty            = (cnt_q == '0);
        err              = err_q;
    end

endmodule

// File: tb/tb_rob_tag_alloc.sv
// Self-checking bench for rob_tag_alloc with ROB_WIDTH=2 (three usable tags).
// Reference model: queue of in-flight tags plus the next tag to hand out.
module tb_rob_tag_alloc;

    localparam int W = 2;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rdy = 1'b1;
    logic         clr = 1'b0;
    logic         req = 1'b0;
    logic [4:0]   rd  = '0;
    logic         com = 1'b0;
    logic [W-1:0] cidx = '0;
    logic         iu_grant, rf_issue_ready, full, empty, err;
    logic [W-1:0] iu_tag, rf_issue_rob_idx, head_tag, free_cnt;
    logic [4:0]   rf_issue_rd_id;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state.
    int inflight[$];
    int nt     = 1;
    bit m_err  = 0;

    always #5 clk = ~clk;

    rob_tag_alloc #(.ROB_WIDTH(W)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .rdy_in          (rdy),
        .clr_in          (clr),
        .iu_req          (req),
        .iu_rd_id        (rd),
        .iu_grant        (iu_grant),
        .iu_tag          (iu_tag),
        .rf_issue_ready  (rf_issue_ready),
        .rf_issue_rd_id  (rf_issue_rd_id),
        .rf_issue_rob_idx(rf_issue_rob_idx),
        .rob_commit      (com),
        .rob_commit_idx  (cidx),
        .head_tag        (head_tag),
        .free_cnt        (free_cnt),
        .full            (full),
        .empty           (empty),
        .err             (err)
    );

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_head();
        return (inflight.size() != 0) ? inflight[0] : nt;
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, update model at posedge.
    task automatic cycle(input bit q, input int rdv, input bit c, input int ci,
                         input bit cl, input bit r);
        bit g, ok;
        @(negedge clk);
        req = q; rd = 5'(rdv); com = c; cidx = W'(ci); clr = cl; rdy = r;
        #1;
        g = q && r && !cl && (inflight.size() != N);
        check("iu_grant", int'(iu_grant), int'(g));
        check("rf_issue_ready", int'(rf_issue_ready), int'(g));
        check("iu_tag", int'(iu_tag), nt);
        check("rf_issue_rob_idx", int'(rf_issue_rob_idx), nt);
        check("rf_issue_rd_id", int'(rf_issue_rd_id), rdv);
        check("head_tag", int'(head_tag), model_head());
        check("free_cnt", int'(free_cnt), N - inflight.size());
        check("full", int'(full), int'(inflight.size() == N));
        check("empty", int'(empty), int'(inflight.size() == 0));
        check("err", int'(err), int'(m_err));
        @(posedge clk);
        if (r) begin
            if (cl) begin
                inflight.delete();
                nt = 1;
            end else begin
                ok = c && (inflight.size() != 0) && (ci == model_head());
                if (c && !ok) m_err = 1;
                if (ok) void'(inflight.pop_front());
                if (g) begin
                    inflight.push_back(nt);
                    nt = nt % N + 1;
                end
            end
        end
    endtask

    // Asynchronous reset pulse between clock edges, checked before any edge.
    task automatic async_reset();
        @(negedge clk);
        req = 0; com = 0; clr = 0; rdy = 1;
        #2 rst = 1'b1;
        #1;
        check("rst_head", int'(head_tag), 1);
        check("rst_tag", int'(iu_tag), 1);
        check("rst_err", int'(err), 0);
        check("rst_free", int'(free_cnt), N);
        check("rst_empty", int'(empty), 1);
        #1 rst = 1'b0;
        inflight.delete();
        nt = 1;
        m_err = 0;
    endtask

    initial begin
        int r_req, r_com, r_clr, r_rdy, r_idx;
        #12 rst = 1'b0;

        // Reset / fill: four requests, three grants with tags 1,2,3.
        for (int i = 0; i < 4; i++) cycle(1, i + 3, 0, 0, 0, 1);
        #1;
        check("fill_full", int'(full), 1);
        check("fill_free", int'(free_cnt), 0);

        // Wrap skipping 0: commit tag 1, then request gets tag 1 again.
        cycle(0, 0, 1, 1, 0, 1);
        #1 check("wrap_head", int'(head_tag), 2);
        cycle(1, 7, 0, 0, 0, 1);
        #1 check("wrap_free", int'(free_cnt), 0);

        // Simultaneous grant + commit with tags 1,2 in flight.
        cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 2, 0, 0, 0, 1);
        cycle(1, 9, 1, 1, 0, 1);
        #1;
        check("sim_head", int'(head_tag), 2);
        check("sim_tag", int'(iu_tag), 1);
        check("sim_free", int'(free_cnt), 1);

        // Full + commit same cycle: no grant, then grant next cycle.
        cycle(1, 4, 0, 0, 0, 1);
        cycle(1, 5, 1, 2, 0, 1);
        cycle(1, 6, 0, 0, 0, 1);

        // Clear with two in flight.
        cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 2, 0, 0, 0, 1);
        cycle(1, 3, 0, 0, 1, 1);
        #1 check("clr_empty", int'(empty), 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Wrong-index commit.
        async_reset();
        cycle(1, 1, 0, 0, 0, 1);
        cycle(0, 0, 1, 2, 0, 1);
        #1;
        check("badidx_err", int'(err), 1);
        check("badidx_head", int'(head_tag), 1);

        // Commit when empty.
        async_reset();
        cycle(0, 0, 1, 1, 0, 1);
        #1 check("empty_commit_err", int'(err), 1);

        // rdy low: frozen, commits ignored without err.
        async_reset();
        cycle(1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 2, 1, 3, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        #1;
        check("rdy_tag", int'(iu_tag), 2);
        check("rdy_err", int'(err), 0);

        // Random traffic against the model.
        async_reset();
        for (int i = 0; i < 400; i++) begin
            r_req = int'($urandom_range(0, 9) < 6);
            r_clr = int'($urandom_range(0, 29) == 0);
            r_rdy = int'($urandom_range(0, 9) != 0);
            r_com = r_clr ? 0 : int'($urandom_range(0, 9) < 4);
            r_idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N)) : model_head();
            cycle(r_req[0], int'($urandom_range(0, 31)), r_com[0], r_idx, r_clr[0], r_rdy[0]);
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_tag_alloc.md
# rob_tag_alloc

Allocator for ROB tags, the rename identifiers written into the register file's dependency table. Issue-unit requests are granted against a circular pool of non-zero tags. Each grant drives the register file's issue write (rd id plus tag) in the same cycle. Tags are reclaimed in order as the ROB commits, and the pool resets on a pipeline clear. Tag 0 is never handed out, because it is the register file's "no dependency" value.

## Interface
- ROB_WIDTH, default 4: tag width; usable tags are 1..2^ROB_WIDTH-1, so the pool holds N = 2^ROB_WIDTH-1 tags.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  ready; when low, state holds and grant is 0
- clr_in  in  1  pipeline clear (misprediction); synchronous pool reset
- iu_req  in  1  issue unit requests a tag
- iu_rd_id  in  5  destination register of the requesting instruction
- iu_grant  out  1  request accepted this cycle
- iu_tag  out  ROB_WIDTH  tag assigned; valid when iu_grant
- rf_issue_ready  out  1  register file dependency write enable
- rf_issue_rd_id  out  5  register file dependency write register
- rf_issue_rob_idx  out  ROB_WIDTH  register file dependency write tag
- rob_commit  in  1  ROB retires its head entry
- rob_commit_idx  in  ROB_WIDTH  tag being retired
- head_tag  out  ROB_WIDTH  oldest in-flight tag
- free_cnt  out  ROB_WIDTH  number of unallocated tags, 0..N
- full  out  1  free_cnt == 0
- empty  out  1  free_cnt == N
- err  out  1  sticky protocol-violation flag

## Operation
- State registers: head, tail (next tag to give), cnt (in-flight tags, 0..N), err.
- Reset values: head=1, tail=1, cnt=0, err=0.
  - Resulting outputs: head_tag=1, iu_tag=1, free_cnt=N, empty=1, full=0, iu_grant=0, rf_issue_ready=0.
- Pointer advance: next(p) = (p == N) ? 1 : p+1. A pointer never takes the value 0.
- Grant rule: iu_grant = iu_req & rdy_in & !clr_in & (cnt != N).
  - The full condition comes from registered cnt. A commit in the same cycle does not bypass into the grant.
- Register file drive:
  - iu_tag = tail.
  - rf_issue_ready = iu_grant.
  - rf_issue_rd_id = iu_rd_id.
  - rf_issue_rob_idx = tail.
  - The register file itself ignores rd=0; this block still grants and allocates a tag for rd=0.
- Commit rule:
  - A commit is valid when rob_commit & rdy_in & !clr_in & cnt != 0 & rob_commit_idx == head.
  - Valid commit: head <= next(head).
  - Commit with cnt == 0, or with rob_commit_idx != head: ignored, err <= 1.
- Count update:
  - cnt <= cnt + grant - valid_commit.
  - Grant and valid commit in the same cycle: cnt unchanged, both pointers advance.
- Clear: clr_in & rdy_in at a posedge sets head=1, tail=1, cnt=0. err is unaffected. No grant and no commit take effect in a clear cycle.
- rdy_in low: all registers hold and iu_grant=0. rob_commit is ignored and does not set err.
- err clears only on rst_in.
- free_cnt = N - cnt.

## Timing
- iu_grant, iu_tag and rf_issue_* are combinational from registered state and current inputs. Grant takes effect at the next posedge, where the register file samples rf_issue_*.
- Allocation: tail advances at the posedge of the grant cycle, so the next request sees the following tag.
- Reclaim latency: a tag freed by a commit is grantable starting the cycle after the commit edge.
- Back-to-back grants are allowed every cycle until full.
- Asserting rst_in mid-operation immediately sets all registers to their reset values, with no clock required.
- Outputs are glitch-relevant only at posedge; no multicycle paths.

## Test plan
Use ROB_WIDTH=2, so N=3.
- **Reset / fill:** after rst_in, hold iu_req=1 for 4 cycles.
  - iu_tag sequence 1,2,3; grant on the first three cycles, no grant on the fourth.
  - After three grants full=1, free_cnt=0.
  - rf_issue_rob_idx matches iu_tag and rf_issue_rd_id matches iu_rd_id on every grant.
- **Wrap skipping 0:** fill (tags 1,2,3), commit tag 1, then request.
  - Granted tag is 1, never 0.
  - head_tag goes 1→2; free_cnt goes 0→1→0.
- **Simultaneous grant + commit:** with cnt=2 (tags 1,2 in flight), assert iu_req and rob_commit with idx 1 in the same cycle.
  - Grant with tag 3.
  - Next cycle: cnt=2, head_tag=2, iu_tag=1.
- **Full + commit same cycle:** with cnt=3, assert iu_req and a valid commit together.
  - iu_grant=0; cnt becomes 2.
  - Next cycle the request is granted.
- **Clear:** with 2 tags in flight, assert clr_in with iu_req=1.
  - iu_grant=0 in the clear cycle.
  - Next cycle: head_tag=1, iu_tag=1, empty=1.
- **Protocol errors and rdy:** each of the following is run separately.
  - rob_commit with idx 2 when head=1: err=1, head unchanged.
  - rob_commit when empty: err=1.
  - rdy_in=0 with iu_req=1 for 3 cycles: no grant, state frozen.
  - rst_in pulsed asynchronously between edges: err=0 and pointers=1 immediately.
